sumador_segmentado: RTL and testbench

Parametrised pipelined carry-segmented adder/subtractor, the successor to the fixed-width combinational segment adders. Operands are split into SEG_WIDTH segments. One segment is added per pipeline stage, and the carry is registered between stages. Full throughput is one operation per cycle. Provides a valid/ready handshake for use on the datapath at full WIDTH (default 64) without a long combinational carry chain.

---
 rtl/sumador_segmentado.sv | 162 ++++++++++++++++
 tb/tb_sumador_segmentado.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_segmentado.sv
// Pipelined carry-segmented adder/subtractor: one SEG_WIDTH slice per stage,
// carry registered between stages, valid/ready with a single global advance.

module sumador_seg_add #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);
    logic [SW:0] t;

    assign t  = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
    assign s  = t[SW-1:0];
    assign co = t[SW];
endmodule

module sumador_segmentado #(
    parameter int WIDTH     = 64,
    parameter int SEG_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SW   = SEG_WIDTH;
    localparam int NSEG = WIDTH / SEG_WIDTH;
    // Skew/deskew storage is triangular; each stage owns a slice of these buses.
    localparam int OTOT = (NSEG - 1) * WIDTH - SW * (NSEG - 1) * NSEG / 2;
    localparam int OTW  = (OTOT > 0) ? OTOT : 1;
    localparam int STOT = SW * NSEG * (NSEG + 1) / 2;

    if (SEG_WIDTH < 1 || (WIDTH % SEG_WIDTH) != 0) begin : g_bad_cfg
        $error("sumador_segmentado: WIDTH must be a multiple of SEG_WIDTH");
    end

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [NSEG-1:0]  vld_pipe;

    wire  [OTW-1:0]   op_a;
    wire  [OTW-1:0]   op_b;
    wire  [STOT-1:0]  sum_tri;
    wire  [NSEG-1:0]  cy;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? ~cin : cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (advance) begin
            vld_pipe[0] <= accept;
            for (int k = 1; k < NSEG; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    assign out_valid = vld_pipe[NSEG-1];

    if (NSEG == 1) begin : g_no_skew
        assign op_a = '0;
        assign op_b = '0;
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int INW  = WIDTH - k * SW;   // operand bits not yet added
        localparam int SUMW = (k + 1) * SW;     // result bits finished after this stage
        localparam int SOFF = SW * k * (k + 1) / 2;

        logic [INW-1:0]  a_in;
        logic [INW-1:0]  b_in;
        logic            ci;
        logic [SW-1:0]   s_seg;
        logic            co;
        logic [SUMW-1:0] s_d;
        logic [SUMW-1:0] s_q;
        logic            c_q;

        if (k == 0) begin : g_in
            assign a_in = a;
            assign b_in = b_eff;
            assign ci   = c0;
            assign s_d  = s_seg;
        end else begin : g_in
            localparam int IOFF = (k - 1) * WIDTH - SW * (k - 1) * k / 2;
            assign a_in = op_a[IOFF +: INW];
            assign b_in = op_b[IOFF +: INW];
            assign ci   = cy[k-1];
            assign s_d  = {s_seg, sum_tri[SOFF - k * SW +: k * SW]};
        end

        sumador_seg_add #(.SW(SW)) u_add (
            .a  (a_in[SW-1:0]),
            .b  (b_in[SW-1:0]),
            .ci (ci),
            .s  (s_seg),
            .co (co)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (advance) begin
                s_q <= s_d;
                c_q <= co;
            end
        end

        assign sum_tri[SOFF +: SUMW] = s_q;
        assign cy[k]                 = c_q;

        if (k < NSEG - 1) begin : g_op
            localparam int OOFF = k * WIDTH - SW * k * (k + 1) / 2;
            logic [INW-SW-1:0] a_q;
            logic [INW-SW-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[INW-1:SW];
                    b_q <= b_in[INW-1:SW];
                end
            end

            assign op_a[OOFF +: INW-SW] = a_q;
            assign op_b[OOFF +: INW-SW] = b_q;
        end else begin : g_last
            logic ovf_q;

            // carry into the MSB is recovered from the MSB sum bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst)          ovf_q <= 1'b0;
                else if (advance) ovf_q <= co ^ (a_in[SW-1] ^ b_in[SW-1] ^ s_seg[SW-1]);
            end

            assign ovf = ovf_q;
        end
    end

    assign sum  = sum_tri[STOT-1 -: WIDTH];
    assign cout = cy[NSEG-1];
endmodule

// File: tb/tb_sumador_segmentado.sv
// Scoreboard bench for sumador_segmentado: expectations queued at accept,
// checked when results are consumed; latency, hold and reset flush checked.

module tb_sumador_segmentado;
    localparam int WIDTH = 64;
    localparam int NSEG  = 4;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        v;
        int          lat;
        int          cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   cyc     = 0;
    exp_t q[$];
    exp_t pend;
    logic        hold_prev = 1'b0;
    logic [63:0] hold_sum;

    sumador_segmentado #(.WIDTH(WIDTH), .SEG_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [64:0] t;
        logic [63:0] yy;
        yy    = sb ? ~y : y;
        t     = {1'b0, x} + {1'b0, yy} + {64'd0, sb ? ~ci : ci};
        e.s   = t[63:0];
        e.c   = t[64];
        e.v   = (x[63] == yy[63]) && (t[63] != x[63]);
        e.lat = -1;
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: everything sampled at negedge, mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_prev = 1'b0;
        end else begin
            cyc++;
            if (hold_prev) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_sum", sum, hold_sum);
            end
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", {63'd0, in_ready}, 64'd0);
                hold_prev = 1'b1;
                hold_sum  = sum;
            end else begin
                hold_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", sum, e.s);
                    chk("cout", {63'd0, cout}, {63'd0, e.c});
                    chk("ovf", {63'd0, ovf}, {63'd0, e.v});
                    if (e.lat >= 0) chk("latency", 64'(cyc - e.cyc), 64'(e.lat));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e     = pend;
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic ci,
                        input logic sb, input exp_t e);
        logic ok;
        ok       = 1'b0;
        pend     = e;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = sb;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_k(input logic [63:0] x, input logic [63:0] y, input logic ci,
                          input logic sb, input logic [63:0] es, input logic ec,
                          input logic ev, input int lat);
        exp_t e;
        e.s   = es;
        e.c   = ec;
        e.v   = ev;
        e.lat = lat;
        e.cyc = 0;
        send(x, y, ci, sb, e);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int n0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // carry ripple and overflow corners
        send_k(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, NSEG);
        drain();
        send_k(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, NSEG);
        send_k(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, NSEG);
        drain();

        // subtraction with borrow
        send_k(64'd5, 64'd3, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, NSEG);
        send_k(64'd3, 64'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, NSEG);
        send_k(64'd5, 64'd3, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, NSEG);
        drain();

        // streaming with a 3-cycle stall on the 2nd result
        n0 = n_out;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send_k(64'(i), 64'(i) << 16, 1'b0, 1'b0, 64'(i) + (64'(i) << 16), 1'b0, 1'b0, -1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    if (n_out == n0 + 1 && out_valid) begin
                        out_ready = 1'b0;
                        repeat (3) @(posedge clk);
                        #1;
                        out_ready = 1'b1;
                        break;
                    end
                end
            end
        join
        drain();
        chk("stream_count", 64'(n_out - n0), 64'd6);

        // random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [63:0] x, y;
                    logic ci, sb;
                    x  = {$urandom(), $urandom()};
                    y  = {$urandom(), $urandom()};
                    ci = 1'($urandom_range(0, 1));
                    sb = 1'($urandom_range(0, 1));
                    send(x, y, ci, sb, model(x, y, ci, sb));
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // asynchronous reset while a result is held at the output
        out_ready = 1'b0;
        send_k(64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0, -1);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_sum", sum, 64'd0);
        chk("arst_cout", {63'd0, cout}, 64'd0);
        chk("arst_ovf", {63'd0, ovf}, 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);

        // reset with two ops in flight: nothing may emerge afterwards
        send_k(64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0, -1);
        send_k(64'd11, 64'd21, 1'b0, 1'b0, 64'd32, 1'b0, 1'b0, -1);
        n0 = n_out;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_no_out", 64'(n_out - n0), 64'd0);
        send_k(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0,
               64'h0000_0001_0001_0000, 1'b0, 1'b0, NSEG);
        drain();
        chk("post_rst_count", 64'(n_out - n0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
